// File: rtl/axi_frame_pkg.sv
// axi_frame_pkg
//   Shared definitions for the colour-fill frame traffic blocks:
//   reader FSM state encoding, fixed AXI3 read-channel field values and
//   the colour table (index -> 24-bit R/G/B).
//   No ports; imported with import axi_frame_pkg::*.
package axi_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] AR_CACHE   = 4'b0011;
  localparam logic [2:0] AR_PROT    = 3'b000;
  localparam logic       AR_LOCK    = 1'b0;
  localparam logic [3:0] AR_QOS     = 4'b0000;

  // Colour pass index to {R,G,B}; unused indices give black.
  function automatic logic [23:0] color_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    color_rgb = 24'hFF0000;
      3'd1:    color_rgb = 24'h00FF00;
      3'd2:    color_rgb = 24'h0000FF;
      3'd3:    color_rgb = 24'hFFFF00;
      3'd4:    color_rgb = 24'hFF00FF;
      3'd5:    color_rgb = 24'h00FFFF;
      3'd6:    color_rgb = 24'hFFFFFF;
      default: color_rgb = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/axi_frame_reader_if.sv
// axi_frame_reader_if
//   AXI3 read address / read data channels between a read master and a
//   slave port. Parameters ADDR_W, DATA_W.
//   master modport: drives AR fields, arvalid, rready.
//   slave modport : drives arready, rdata, rresp, rlast, rvalid.
interface axi_frame_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arlock;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
    output arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
    input  arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_frame_pattern.sv
// axi_frame_pattern
//   Registered colour-index to data-word expander: every 32-bit lane of
//   the output holds {8'h00,R,G,B} for the selected colour. Used by both
//   the frame reader and the write-side generator.
//   Ports: clk, rst (async, active high), idx[2:0] colour index,
//          expected[DATA_W-1:0] registered pattern word.
module axi_frame_pattern
  import axi_frame_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        idx,
  output logic [DATA_W-1:0] expected
);

  logic [23:0]       rgb;
  logic [DATA_W-1:0] pattern_next;

  assign rgb = color_rgb(idx);

  for (genvar gi = 0; gi < DATA_W / 32; gi++) begin : g_lane
    assign pattern_next[gi*32 +: 32] = {8'h00, rgb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) expected <= '0;
    else     expected <= pattern_next;
  end

endmodule

// File: rtl/axi_frame_reader.sv
// axi_frame_reader
//   AXI3 read master that sweeps ADDR_START..ADDR_END with INCR bursts of
//   BURST_LEN beats, compares each beat with the solid colour of the
//   current pass and counts mismatches. At the end of the region the
//   address wraps, the colour index advances and frame_done pulses.
//   Ports: aclk, areset (async, active high), start (level enable),
//          m_axi (read master), busy, frame_done, frame_count[15:0],
//          err_count[31:0] (saturating), resp_err (sticky).
//   Optional build macro AXI_RD_ERR_CAPTURE_EN adds first_err_addr,
//   first_err_data and first_err_valid, latched on the first mismatch.
module axi_frame_reader
  import axi_frame_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 64,
  parameter int              BURST_LEN  = 16,
  parameter logic [ADDR_W-1:0] ADDR_START = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] ADDR_END   = 32'h101F_A3F0,
  parameter int              NUM_COLORS = 7
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  axi_frame_reader_if.master  m_axi,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic [31:0]         err_count,
`ifdef AXI_RD_ERR_CAPTURE_EN
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic                first_err_valid,
`endif
  output logic                resp_err
);

  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        idx_reg;
  logic [3:0]        beat_reg;
  logic [15:0]       frame_count_reg;
  logic [31:0]       err_count_reg;
  logic              resp_err_reg;
  logic              frame_done_reg;
  logic [DATA_W-1:0] expected;
  logic              beat_fire;
  logic              last_beat;
  logic              mismatch;
  logic [ADDR_W:0]   next_addr;
  logic              wrap;

  // idx only moves on the last beat, so the registered pattern has
  // settled again before the first beat of the following burst.
  axi_frame_pattern #(.DATA_W(DATA_W)) u_pattern (
    .clk      (aclk),
    .rst      (areset),
    .idx      (idx_reg),
    .expected (expected)
  );

  assign m_axi.araddr  = addr_reg;
  assign m_axi.arlen   = 4'(BURST_LEN - 1);
  assign m_axi.arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arcache = AR_CACHE;
  assign m_axi.arprot  = AR_PROT;
  assign m_axi.arlock  = AR_LOCK;
  assign m_axi.arqos   = AR_QOS;
  assign m_axi.arvalid = (state_reg == ST_ADDR);
  assign m_axi.rready  = (state_reg == ST_DATA);

  assign busy        = (state_reg != ST_IDLE);
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign err_count   = err_count_reg;
  assign resp_err    = resp_err_reg;

  assign beat_fire = m_axi.rvalid && (state_reg == ST_DATA);
  assign last_beat = (beat_reg == 4'(BURST_LEN - 1));
  assign mismatch  = (m_axi.rdata != expected);
  // One extra bit so a region ending near the top of the address space
  // still detects the wrap.
  assign next_addr = {1'b0, addr_reg} + (ADDR_W+1)'(BURST_BYTES);
  assign wrap      = (next_addr > {1'b0, ADDR_END});

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_ADDR;
      ST_ADDR: if (m_axi.arready) state_next = ST_DATA;
      ST_DATA: if (beat_fire && last_beat) state_next = start ? ST_ADDR : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_reg        <= ADDR_START;
      idx_reg         <= '0;
      beat_reg        <= '0;
      frame_count_reg <= '0;
      err_count_reg   <= '0;
      resp_err_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (beat_fire) begin
        if (mismatch && (err_count_reg != 32'hFFFF_FFFF))
          err_count_reg <= err_count_reg + 32'd1;
        // The burst length is fixed by the beat counter, not by rlast.
        if ((m_axi.rresp != RESP_OKAY) || (m_axi.rlast != last_beat))
          resp_err_reg <= 1'b1;
        if (last_beat) begin
          beat_reg <= '0;
          if (wrap) begin
            addr_reg        <= ADDR_START;
            idx_reg         <= (idx_reg == 3'(NUM_COLORS - 1)) ? 3'd0 : idx_reg + 3'd1;
            frame_count_reg <= frame_count_reg + 16'd1;
            frame_done_reg  <= 1'b1;
          end else begin
            addr_reg <= next_addr[ADDR_W-1:0];
          end
        end else begin
          beat_reg <= beat_reg + 4'd1;
        end
      end
    end
  end

`ifdef AXI_RD_ERR_CAPTURE_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      first_err_addr  <= '0;
      first_err_data  <= '0;
      first_err_valid <= 1'b0;
    end else if (beat_fire && mismatch && !first_err_valid) begin
      first_err_addr  <= addr_reg + ADDR_W'(beat_reg) * ADDR_W'(BEAT_BYTES);
      first_err_data  <= m_axi.rdata;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_frame_reader.sv
// tb_axi_frame_reader
//   Directed bench for axi_frame_reader with a small 3-burst frame
//   region (0x1000_0000..0x1000_017F). The bench plays the AXI slave:
//   each burst task waits for the AR, optionally stalls arready, then
//   returns 16 beats of the expected colour with optional faults.
//   Compiles with or without AXI_RD_ERR_CAPTURE_EN.
`timescale 1ns/1ps
module tb_axi_frame_reader;
  import axi_frame_pkg::*;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 64;
  localparam logic [31:0] A0     = 32'h1000_0000;
  localparam logic [31:0] AEND   = 32'h1000_017F;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        busy, frame_done, resp_err;
  logic [15:0] frame_count;
  logic [31:0] err_count;
`ifdef AXI_RD_ERR_CAPTURE_EN
  logic [31:0] first_err_addr;
  logic [63:0] first_err_data;
  logic        first_err_valid;
`endif

  int compared = 0;
  int mismatched = 0;
  int ar_hs = 0;
  int done_cnt = 0;

  axi_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

  axi_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(16),
    .ADDR_START(A0), .ADDR_END(AEND), .NUM_COLORS(7)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .m_axi(m_axi),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .err_count(err_count),
`ifdef AXI_RD_ERR_CAPTURE_EN
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .first_err_valid(first_err_valid),
`endif
    .resp_err(resp_err)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (m_axi.arvalid && m_axi.arready) ar_hs <= ar_hs + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Hand-written colour table of the frame generator (R/G/B per pass).
  function automatic logic [63:0] exp_word(input logic [2:0] i);
    logic [23:0] rgb;
    case (i)
      3'd0: rgb = 24'hFF0000;
      3'd1: rgb = 24'h00FF00;
      3'd2: rgb = 24'h0000FF;
      3'd3: rgb = 24'hFFFF00;
      3'd4: rgb = 24'hFF00FF;
      3'd5: rgb = 24'h00FFFF;
      default: rgb = 24'hFFFFFF;
    endcase
    return {8'h00, rgb, 8'h00, rgb};
  endfunction

  task automatic apply_reset();
    start = 1'b0;
    m_axi.arready = 1'b0;
    m_axi.rvalid = 1'b0;
    m_axi.rlast = 1'b0;
    m_axi.rresp = 2'b00;
    m_axi.rdata = '0;
    @(negedge aclk);
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  // One full AR + 16-beat read burst as the slave.
  task automatic burst(input logic [2:0] cidx, input logic [31:0] exp_addr,
                       input int zero_beat, input int resp_beat,
                       input int last_pos, input int ar_delay);
    int   wait_n;
    int   hs0;
    logic stable;
    logic beats_ok;
    logic [31:0] a_seen;
    wait_n = 0;
    while (!m_axi.arvalid && wait_n < 200) begin
      @(negedge aclk);
      wait_n++;
    end
    compared++;
    if (!m_axi.arvalid) begin
      mismatched++;
      $display("FAIL ar_timeout: arvalid=%0b required 1 within 200 cycles", m_axi.arvalid);
      return;
    end
    compared++;
    if (m_axi.araddr !== exp_addr) begin
      mismatched++;
      $display("FAIL araddr: got %h required %h", m_axi.araddr, exp_addr);
    end
    a_seen = m_axi.araddr;
    stable = 1'b1;
    for (int d = 0; d < ar_delay; d++) begin
      m_axi.arready = 1'b0;
      @(negedge aclk);
      if (m_axi.arvalid !== 1'b1 || m_axi.araddr !== a_seen || m_axi.arlen !== 4'd15)
        stable = 1'b0;
    end
    if (ar_delay > 0) begin
      compared++;
      if (stable !== 1'b1) begin
        mismatched++;
        $display("FAIL ar_stable: stable=%0b required 1 over %0d stall cycles", stable, ar_delay);
      end
    end
    hs0 = ar_hs;
    m_axi.arready = 1'b1;
    @(negedge aclk);
    m_axi.arready = 1'b0;
    compared++;
    if (ar_hs - hs0 !== 1) begin
      mismatched++;
      $display("FAIL ar_handshakes: got %0d required 1", ar_hs - hs0);
    end
    beats_ok = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (m_axi.rready !== 1'b1 || m_axi.arvalid !== 1'b0) beats_ok = 1'b0;
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = (b == zero_beat) ? 64'h0 : exp_word(cidx);
      m_axi.rresp  = (b == resp_beat) ? 2'b10 : 2'b00;
      m_axi.rlast  = (b == last_pos);
      @(negedge aclk);
    end
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    m_axi.rresp  = 2'b00;
    compared++;
    if (beats_ok !== 1'b1) begin
      mismatched++;
      $display("FAIL beat_phase: ok=%0b required 1 (rready high, no AR, 16 beats)", beats_ok);
    end
    $display("burst addr=%h colour=%0d err_count=%0d resp_err=%0b", a_seen, cidx, err_count, resp_err);
  endtask

  task automatic clean_frame(input logic [2:0] cidx);
    for (int k = 0; k < 3; k++)
      burst(cidx, A0 + 32'(k) * 32'h80, -1, -1, 15, 0);
  endtask

  task automatic test_reset();
    apply_reset();
    compared++;
    if ({m_axi.arvalid, m_axi.rready, busy, frame_done, resp_err} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: arvalid/rready/busy/done/resp_err=%b required 00000",
               {m_axi.arvalid, m_axi.rready, busy, frame_done, resp_err});
    end
    compared++;
    if (frame_count !== 16'd0 || err_count !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_counts: frame_count=%0d err_count=%0d required 0/0", frame_count, err_count);
    end
    compared++;
    if ({m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arcache, m_axi.arprot, m_axi.arlock, m_axi.arqos}
        !== {4'hF, 3'd3, 2'b01, 4'b0011, 3'b000, 1'b0, 4'b0000}) begin
      mismatched++;
      $display("FAIL reset_ar_const: len=%h size=%h burst=%h cache=%h prot=%h lock=%b qos=%h required f/3/1/3/0/0/0",
               m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arcache, m_axi.arprot, m_axi.arlock, m_axi.arqos);
    end
  endtask

  task automatic test_clean_frame();
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    clean_frame(3'd0);
    @(negedge aclk);
    compared++;
    if (err_count !== 32'd0 || resp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL clean_errs: err_count=%0d resp_err=%0b required 0/0", err_count, resp_err);
    end
    compared++;
    if (frame_count !== 16'd1 || done_cnt - d0 !== 1) begin
      mismatched++;
      $display("FAIL clean_frame: frame_count=%0d done_pulses=%0d required 1/1", frame_count, done_cnt - d0);
    end
  endtask

  task automatic test_mismatch();
    burst(3'd1, A0, 5, -1, 15, 0);
    compared++;
    if (err_count !== 32'd1) begin
      mismatched++;
      $display("FAIL mismatch_count: err_count=%0d required 1", err_count);
    end
`ifdef AXI_RD_ERR_CAPTURE_EN
    compared++;
    if (first_err_valid !== 1'b1 || first_err_addr !== A0 + 32'h28 || first_err_data !== 64'h0) begin
      mismatched++;
      $display("FAIL first_err: valid=%0b addr=%h data=%h required 1/%h/0",
               first_err_valid, first_err_addr, first_err_data, A0 + 32'h28);
    end
`endif
    burst(3'd1, A0 + 32'h80, -1, -1, 15, 0);
    burst(3'd1, A0 + 32'h100, 2, -1, 15, 0);
    compared++;
    if (err_count !== 32'd2 || resp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL mismatch_second: err_count=%0d resp_err=%0b required 2/0", err_count, resp_err);
    end
`ifdef AXI_RD_ERR_CAPTURE_EN
    compared++;
    if (first_err_addr !== A0 + 32'h28) begin
      mismatched++;
      $display("FAIL first_err_hold: addr=%h required %h", first_err_addr, A0 + 32'h28);
    end
`endif
  endtask

  task automatic test_ar_stall();
    burst(3'd2, A0, -1, -1, 15, 20);
    burst(3'd2, A0 + 32'h80, -1, -1, 15, 3);
    burst(3'd2, A0 + 32'h100, -1, -1, 15, 0);
    @(negedge aclk);
    compared++;
    if (err_count !== 32'd2 || frame_count !== 16'd3) begin
      mismatched++;
      $display("FAIL stall_frame: err_count=%0d frame_count=%0d required 2/3", err_count, frame_count);
    end
  endtask

  task automatic test_early_rlast();
    burst(3'd3, A0, -1, -1, 14, 0);
    compared++;
    if (resp_err !== 1'b1) begin
      mismatched++;
      $display("FAIL early_rlast: resp_err=%0b required 1", resp_err);
    end
    burst(3'd3, A0 + 32'h80, -1, -1, 15, 0);
    burst(3'd3, A0 + 32'h100, -1, -1, 15, 0);
    compared++;
    if (err_count !== 32'd2 || frame_count !== 16'd4) begin
      mismatched++;
      $display("FAIL early_rlast_frame: err_count=%0d frame_count=%0d required 2/4", err_count, frame_count);
    end
  endtask

  task automatic test_resp_err();
    apply_reset();
    compared++;
    if (resp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL resp_err_cleared: resp_err=%0b required 0", resp_err);
    end
    start = 1'b1;
    burst(3'd0, A0, -1, -1, 15, 0);
    burst(3'd0, A0 + 32'h80, -1, 3, 15, 0);
    compared++;
    if (resp_err !== 1'b1 || err_count !== 32'd0) begin
      mismatched++;
      $display("FAIL resp_err_set: resp_err=%0b err_count=%0d required 1/0", resp_err, err_count);
    end
    burst(3'd0, A0 + 32'h100, -1, -1, 15, 0);
    clean_frame(3'd1);
    compared++;
    if (resp_err !== 1'b1) begin
      mismatched++;
      $display("FAIL resp_err_sticky: resp_err=%0b required 1", resp_err);
    end
  endtask

  task automatic test_frames();
    int d0;
    apply_reset();
    d0 = done_cnt;
    start = 1'b1;
    for (int f = 0; f < 7; f++) clean_frame(3'(f));
    @(negedge aclk);
    compared++;
    if (done_cnt - d0 !== 7 || frame_count !== 16'd7) begin
      mismatched++;
      $display("FAIL seven_frames: done_pulses=%0d frame_count=%0d required 7/7", done_cnt - d0, frame_count);
    end
    burst(3'd0, A0, -1, -1, 15, 0);
    compared++;
    if (err_count !== 32'd0 || resp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL colour_wrap: err_count=%0d resp_err=%0b required 0/0 (red again)", err_count, resp_err);
    end
  endtask

  task automatic test_reset_mid();
    int wait_n;
    // DUT is now waiting on the AR for A0+0x80; accept it and send 5 beats.
    wait_n = 0;
    while (!m_axi.arvalid && wait_n < 200) begin
      @(negedge aclk);
      wait_n++;
    end
    m_axi.arready = 1'b1;
    @(negedge aclk);
    m_axi.arready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = exp_word(3'd0);
      @(negedge aclk);
    end
    m_axi.rvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    compared++;
    if ({m_axi.arvalid, m_axi.rready, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_mid: arvalid/rready/busy=%b required 000", {m_axi.arvalid, m_axi.rready, busy});
    end
    areset = 1'b0;
    burst(3'd0, A0, -1, -1, 15, 0);
    compared++;
    if (err_count !== 32'd0 || frame_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_mid_after: err_count=%0d frame_count=%0d required 0/0", err_count, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_mismatch();
    test_ar_stall();
    test_early_rlast();
    test_resp_err();
    test_frames();
    test_reset_mid();
    start = 1'b0;
    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
